// File: rtl/branch_history_predictor.sv
// Per-PC branch direction predictor: a table of saturating counters indexed by PC, plus an
// in-order pending queue so the execute stage only has to report the actual outcome.
module branch_history_predictor #(
  parameter int unsigned Entries   = 16,
  parameter int unsigned CtrW      = 2,
  parameter int unsigned InitCtr   = 2 ** (CtrW - 1) - 1,
  parameter int unsigned PendDepth = 4,
  parameter int unsigned Xlen      = 32,
  parameter int unsigned StatW     = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         freeze_i,
  input  logic                         flush_tbl_i,
  input  logic                         pred_valid_i,
  input  logic [Xlen-1:0]              pred_pc_i,
  input  logic [Xlen-1:0]              pred_imm_i,
  output logic                         pred_ready_o,
  output logic                         pred_taken_o,
  output logic [Xlen-1:0]              pred_next_pc_o,
  input  logic                         res_valid_i,
  input  logic                         res_taken_i,
  output logic                         res_mispredict_o,
  output logic [$clog2(PendDepth):0]   pend_count_o,
  output logic [StatW-1:0]             br_count_o,
  output logic [StatW-1:0]             mp_count_o,
  output logic                         err_underflow_o
);

  localparam int unsigned IdxW  = $clog2(Entries);
  localparam int unsigned PtrW  = $clog2(PendDepth);
  localparam int unsigned PendW = PtrW + 1;
  localparam logic [CtrW-1:0] CtrMax  = '1;
  localparam logic [CtrW-1:0] CtrInit = CtrW'(InitCtr);

  typedef struct packed {
    logic [IdxW-1:0] idx;
    logic            taken;
  } pend_t;

  logic [CtrW-1:0]  ctr_q [Entries];
  logic [CtrW-1:0]  ctr_d [Entries];
  pend_t            pend_q [PendDepth];
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PendW-1:0] count_q, count_d;
  logic [StatW-1:0] br_q, br_d, mp_q, mp_d;
  logic             err_q, err_d;

  logic [IdxW-1:0]  lookup_idx;
  pend_t            head;
  logic             empty, pop, push, mp_flush;

  assign lookup_idx     = pred_pc_i[IdxW+1:2];
  assign pred_taken_o   = ctr_q[lookup_idx][CtrW-1];
  assign pred_next_pc_o = pred_taken_o ? pred_pc_i + pred_imm_i : pred_pc_i + Xlen'(4);

  assign head             = pend_q[head_q];
  assign empty            = (count_q == '0);
  assign pred_ready_o     = (count_q < PendW'(PendDepth));
  assign res_mispredict_o = res_valid_i & ~empty & (head.taken != res_taken_i);

  assign pop      = res_valid_i & ~empty & ~freeze_i;
  // A mispredict squashes every younger entry, including one arriving this cycle.
  assign mp_flush = pop & res_mispredict_o;
  assign push     = pred_valid_i & pred_ready_o & ~freeze_i & ~mp_flush;

  always_comb begin
    head_d  = head_q + PtrW'(pop);
    tail_d  = tail_q + PtrW'(push);
    count_d = count_q + PendW'(push) - PendW'(pop);
    if (mp_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_comb begin
    ctr_d = ctr_q;
    if (!freeze_i) begin
      if (flush_tbl_i) begin
        for (int i = 0; i < int'(Entries); i++) ctr_d[i] = CtrInit;
      end else if (pop) begin
        if (res_taken_i) begin
          if (ctr_q[head.idx] != CtrMax) ctr_d[head.idx] = ctr_q[head.idx] + CtrW'(1);
        end else if (ctr_q[head.idx] != '0) begin
          ctr_d[head.idx] = ctr_q[head.idx] - CtrW'(1);
        end
      end
    end
  end

  always_comb begin
    br_d  = (pop && br_q != '1) ? br_q + StatW'(1) : br_q;
    mp_d  = (mp_flush && mp_q != '1) ? mp_q + StatW'(1) : mp_q;
    err_d = err_q | (res_valid_i & empty & ~freeze_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Entries); i++) ctr_q[i] <= CtrInit;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      br_q    <= '0;
      mp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      ctr_q   <= ctr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      br_q    <= br_d;
      mp_q    <= mp_d;
      err_q   <= err_d;
    end
  end

  // Queue storage needs no reset: occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk_i) begin
    if (push) pend_q[tail_q] <= '{idx: lookup_idx, taken: pred_taken_o};
  end

  assign pend_count_o    = count_q;
  assign br_count_o      = br_q;
  assign mp_count_o      = mp_q;
  assign err_underflow_o = err_q;

endmodule

// File: tb/tb_branch_history_predictor.sv
// Scoreboard bench for branch_history_predictor: directed scenarios plus random traffic,
// checked against a queue/array reference model of the predictor rules.
module tb_branch_history_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze, flush_tbl, pred_valid, res_valid, res_taken;
  logic [31:0] pred_pc, pred_imm;
  logic        pred_ready, pred_taken, res_mispredict, err_underflow;
  logic [31:0] pred_next_pc;
  logic [2:0]  pend_count;
  logic [15:0] br_count, mp_count;

  branch_history_predictor dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .freeze_i         (freeze),
    .flush_tbl_i      (flush_tbl),
    .pred_valid_i     (pred_valid),
    .pred_pc_i        (pred_pc),
    .pred_imm_i       (pred_imm),
    .pred_ready_o     (pred_ready),
    .pred_taken_o     (pred_taken),
    .pred_next_pc_o   (pred_next_pc),
    .res_valid_i      (res_valid),
    .res_taken_i      (res_taken),
    .res_mispredict_o (res_mispredict),
    .pend_count_o     (pend_count),
    .br_count_o       (br_count),
    .mp_count_o       (mp_count),
    .err_underflow_o  (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pt;
    logic [31:0] npc;
    logic        rdy;
    logic        mp;
    logic [2:0]  cnt;
    logic [15:0] br;
    logic [15:0] mpc;
    logic        err;
  } exp_t;

  typedef struct {
    int idx;
    bit taken;
  } pe_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  // Reference model state
  int   ctr_m[16];
  pe_t  q_m[$];
  int   br_m, mp_m;
  bit   err_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pred_taken", {31'b0, pred_taken}, {31'b0, e.pt});
      chk("pred_next_pc", pred_next_pc, e.npc);
      chk("pred_ready", {31'b0, pred_ready}, {31'b0, e.rdy});
      chk("res_mispredict", {31'b0, res_mispredict}, {31'b0, e.mp});
      chk("pend_count", {29'b0, pend_count}, {29'b0, e.cnt});
      chk("br_count", {16'b0, br_count}, {16'b0, e.br});
      chk("mp_count", {16'b0, mp_count}, {16'b0, e.mpc});
      chk("err_underflow", {31'b0, err_underflow}, {31'b0, e.err});
    end
  end

  function automatic void model_reset();
    foreach (ctr_m[i]) ctr_m[i] = 1;
    q_m.delete();
    br_m  = 0;
    mp_m  = 0;
    err_m = 0;
  endfunction

  function automatic void idle_inputs();
    freeze     = 0;
    flush_tbl  = 0;
    pred_valid = 0;
    res_valid  = 0;
    res_taken  = 0;
  endfunction

  // One clock: drive inputs, queue expected outputs, then advance the model at the edge.
  task automatic cycle(input bit pv, input logic [31:0] pc, input logic [31:0] imm,
                       input bit rv, input bit rt, input bit frz, input bit fl);
    exp_t e;
    pe_t  h;
    int   idx;
    bit   pt, nonempty, rdy, mp, push;
    pred_valid = pv;
    pred_pc    = pc;
    pred_imm   = imm;
    res_valid  = rv;
    res_taken  = rt;
    freeze     = frz;
    flush_tbl  = fl;
    idx      = int'(pc[5:2]);
    pt       = (ctr_m[idx] >= 2);
    nonempty = (q_m.size() > 0);
    rdy      = (q_m.size() < 4);
    mp       = rv && nonempty && (q_m[0].taken != rt);
    e.pt  = pt;
    e.npc = pt ? pc + imm : pc + 32'd4;
    e.rdy = rdy;
    e.mp  = mp;
    e.cnt = 3'(q_m.size());
    e.br  = 16'(br_m);
    e.mpc = 16'(mp_m);
    e.err = err_m;
    exp_q.push_back(e);
    @(negedge clk);
    if (!frz) begin
      push = pv && rdy;
      if (rv && nonempty) begin
        h = q_m.pop_front();
        if (!fl) begin
          if (rt) ctr_m[h.idx] = (ctr_m[h.idx] < 3) ? ctr_m[h.idx] + 1 : 3;
          else    ctr_m[h.idx] = (ctr_m[h.idx] > 0) ? ctr_m[h.idx] - 1 : 0;
        end
        if (br_m < 65535) br_m++;
        if (mp) begin
          if (mp_m < 65535) mp_m++;
          q_m.delete();
          push = 0;
        end
      end else if (rv) begin
        err_m = 1;
      end
      if (push) q_m.push_back('{idx: idx, taken: pt});
      if (fl) foreach (ctr_m[i]) ctr_m[i] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc, input logic [31:0] imm);
    idle_inputs();
    pred_pc  = pc;
    pred_imm = imm;
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    rst_n = 0;
    idle_inputs();
    pred_pc  = 0;
    pred_imm = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    look(32'h40, 32'h10);
    chk("rst_taken", {31'b0, pred_taken}, 32'd0);
    chk("rst_next_pc", pred_next_pc, 32'h44);
    chk("rst_ready", {31'b0, pred_ready}, 32'd1);
    chk("rst_pend", {29'b0, pend_count}, 32'd0);

    // Train pc 0x40 toward taken
    cycle(1, 32'h40, 32'h10, 0, 0, 0, 0);
    cycle(0, 32'h40, 32'h10, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'h40, 32'h10, 0, 0, 0, 0);
      cycle(0, 32'h40, 32'h10, 1, 1, 0, 0);
    end
    look(32'h40, 32'h10);
    chk("train_next_pc", pred_next_pc, 32'h50);
    chk("train_br", {16'b0, br_count}, 32'd4);
    chk("train_mp", {16'b0, mp_count}, 32'd1);

    // Fill the queue
    for (int i = 0; i < 4; i++) cycle(1, 32'h40, 32'h10, 0, 0, 0, 0);
    chk("full_pend", {29'b0, pend_count}, 32'd4);
    chk("full_ready", {31'b0, pred_ready}, 32'd0);
    cycle(1, 32'h40, 32'h10, 0, 0, 0, 0);
    chk("full_drop", {29'b0, pend_count}, 32'd4);
    cycle(0, 32'h40, 32'h10, 1, 1, 0, 0);
    chk("pop_pend", {29'b0, pend_count}, 32'd3);
    chk("pop_ready", {31'b0, pred_ready}, 32'd1);

    // Head mispredicts with three pending and a same-cycle push
    cycle(1, 32'h40, 32'h10, 1, 0, 0, 0);
    chk("mpflush_pend", {29'b0, pend_count}, 32'd0);
    chk("mpflush_mp", {16'b0, mp_count}, 32'd2);

    look(32'h80, 32'h10);
    chk("alias_taken", {31'b0, pred_taken}, 32'd1);
    chk("alias_next_pc", pred_next_pc, 32'h90);

    cycle(1, 32'hFFFF_FFF0, 32'h20, 0, 0, 0, 0);
    cycle(0, 32'hFFFF_FFF0, 32'h20, 1, 1, 0, 0);
    look(32'hFFFF_FFF0, 32'h20);
    chk("wrap_next_pc", pred_next_pc, 32'h10);

    // Freeze blocks everything
    cycle(1, 32'h40, 32'h10, 0, 0, 0, 0);
    cycle(1, 32'h40, 32'h10, 1, 0, 1, 1);
    chk("frz_pend", {29'b0, pend_count}, 32'd1);
    chk("frz_br", {16'b0, br_count}, 32'd7);
    chk("frz_mp", {16'b0, mp_count}, 32'd3);

    // Underflow is sticky
    cycle(0, 32'h40, 32'h10, 1, 1, 0, 0);
    cycle(0, 32'h40, 32'h10, 1, 1, 0, 0);
    cycle(0, 32'h40, 32'h10, 0, 0, 0, 0);
    chk("uflow_err", {31'b0, err_underflow}, 32'd1);
    chk("uflow_br", {16'b0, br_count}, 32'd8);

    cycle(0, 32'h40, 32'h10, 0, 0, 0, 1);
    look(32'h40, 32'h10);
    chk("flush_taken", {31'b0, pred_taken}, 32'd0);
    chk("flush_next_pc", pred_next_pc, 32'h44);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) cycle(1, 32'h40 + 32'(i * 4), 32'h10, 0, 0, 0, 0);
    chk("pre_rst_pend", {29'b0, pend_count}, 32'd3);
    #2 rst_n = 0;
    #1;
    chk("async_rst_pend", {29'b0, pend_count}, 32'd0);
    chk("async_rst_ready", {31'b0, pred_ready}, 32'd1);
    chk("async_rst_err", {31'b0, err_underflow}, 32'd0);
    chk("async_rst_br", {16'b0, br_count}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      pc = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 7)) << 2) |
           32'($urandom_range(0, 3));
      cycle($urandom_range(0, 99) < 60, pc, $urandom, $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 2);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
